// File: rtl/dsp_ctrl_pkg.sv
// dsp_ctrl_pkg: shared state encoding, transform selects and latency helpers for the DSP core sequencer.
package dsp_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } seq_state_t;

    localparam logic [1:0] T_SEL_8   = 2'b00;
    localparam logic [1:0] T_SEL_16  = 2'b01;
    localparam logic [1:0] T_SEL_32  = 2'b10;
    localparam logic [1:0] T_SEL_EXT = 2'b11;

    localparam int LAT_BASE = 8;

    // Last compute-cycle index for the fixed-latency transforms (L-1).
    function automatic logic [5:0] last_cycle(input logic [1:0] t_sel);
        return 6'(LAT_BASE << t_sel) - 6'd1;
    endfunction

endpackage

// File: rtl/dsp_core_sequencer_seq_counter.sv
// seq_counter: up-counter with synchronous clear, enable and asynchronous reset.
module seq_counter #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= q + 1'b1;
    end

endmodule

// File: rtl/dsp_core_sequencer.sv
// dsp_core_sequencer: loads one block, launches the core, drains results and owns all buffer enables and status flags.
module dsp_core_sequencer
    import dsp_ctrl_pkg::*;
#(
    parameter int BLOCK_LEN = 8,
    parameter int CNT_W     = 16
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         START,
    input  logic [1:0]                   t_select,
    input  logic                         in_valid,
    input  logic                         core_done,
    input  logic                         out_ready,
    output logic                         inputBuffer_en,
    output logic [$clog2(BLOCK_LEN)-1:0] sample_idx,
    output logic                         core_go,
    output logic                         outputBuffer_en,
    output logic                         DataValid,
    output logic                         CoreReady,
    output logic [1:0]                   t_sel_q,
    output logic [CNT_W-1:0]             blk_cnt
);

    localparam int IDX_W = $clog2(BLOCK_LEN);

    seq_state_t state, next_state;
    logic [5:0] cyc;
    logic start_acc, load_wr, drain_xfer, idx_last;
    logic load_done, drain_done, compute_done;

    assign start_acc  = (state == IDLE) && START;
    assign load_wr    = (state == LOAD) && in_valid;
    assign drain_xfer = (state == DRAIN) && out_ready;
    assign idx_last   = sample_idx == IDX_W'(BLOCK_LEN - 1);
    assign load_done  = load_wr && idx_last;
    assign drain_done = drain_xfer && idx_last;
    // core_go is high only in the first COMPUTE cycle, so it masks a coincident core_done.
    assign compute_done = (state == COMPUTE) &&
        ((t_sel_q == T_SEL_EXT) ? (core_done && !core_go) : (cyc == last_cycle(t_sel_q)));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            core_go <= 1'b0;
            t_sel_q <= T_SEL_8;
        end else begin
            state   <= next_state;
            core_go <= load_done;
            t_sel_q <= start_acc ? t_select : t_sel_q;
        end
    end

    always_comb begin
        next_state      = state;
        inputBuffer_en  = 1'b0;
        DataValid       = 1'b0;
        outputBuffer_en = 1'b0;
        CoreReady       = 1'b0;
        case (state)
            IDLE: begin
                CoreReady = 1'b1;
                if (START)
                    next_state = LOAD;
            end
            LOAD: begin
                inputBuffer_en = 1'b1;
                if (load_done)
                    next_state = COMPUTE;
            end
            COMPUTE: begin
                if (compute_done)
                    next_state = DRAIN;
            end
            DRAIN: begin
                DataValid       = 1'b1;
                outputBuffer_en = 1'b1;
                if (drain_done)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    seq_counter #(.W(IDX_W)) u_idx (
        .CLK   (CLK),
        .RESET (RESET),
        .clr   (start_acc || load_done || drain_done),
        .en    (load_wr || drain_xfer),
        .q     (sample_idx)
    );

    seq_counter #(.W(6)) u_cyc (
        .CLK   (CLK),
        .RESET (RESET),
        .clr   (load_done),
        .en    (state == COMPUTE),
        .q     (cyc)
    );

    seq_counter #(.W(CNT_W)) u_blk (
        .CLK   (CLK),
        .RESET (RESET),
        .clr   (1'b0),
        .en    (drain_done),
        .q     (blk_cnt)
    );

endmodule

// File: tb/tb_dsp_core_sequencer.sv
// tb_dsp_core_sequencer: randomized block-level checks of the sequencer against a counting reference model.
module tb_dsp_core_sequencer;

    localparam int BLOCK_LEN = 8;
    localparam int CNT_W     = 4;

    logic       CLK = 1'b0;
    logic       RESET, START, in_valid, core_done, out_ready;
    logic [1:0] t_select;
    logic       inputBuffer_en, core_go, outputBuffer_en, DataValid, CoreReady;
    logic [2:0] sample_idx;
    logic [1:0] t_sel_q;
    logic [CNT_W-1:0] blk_cnt;

    int total = 0;
    int bad = 0;
    int exp_blk = 0;

    dsp_core_sequencer #(.BLOCK_LEN(BLOCK_LEN), .CNT_W(CNT_W)) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .START           (START),
        .t_select        (t_select),
        .in_valid        (in_valid),
        .core_done       (core_done),
        .out_ready       (out_ready),
        .inputBuffer_en  (inputBuffer_en),
        .sample_idx      (sample_idx),
        .core_go         (core_go),
        .outputBuffer_en (outputBuffer_en),
        .DataValid       (DataValid),
        .CoreReady       (CoreReady),
        .t_sel_q         (t_sel_q),
        .blk_cnt         (blk_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values();
        chk("rst_ready", CoreReady, 1);
        chk("rst_ibuf", inputBuffer_en, 0);
        chk("rst_go", core_go, 0);
        chk("rst_valid", DataValid, 0);
        chk("rst_obuf", outputBuffer_en, 0);
        chk("rst_idx", sample_idx, 0);
        chk("rst_tsel", t_sel_q, 0);
        chk("rst_blk", blk_cnt, 0);
    endtask

    // One full block: model counts writes, compute cycles, transfers and edges from the rules alone.
    task automatic run_block(input logic [1:0] ts, input int ext_dly, input bit stall, input bit hold);
        int writes, xfers, cyc, edges, lat, guard;
        lat = (ts == 2'b11) ? ext_dly + 1 : (8 << ts);
        chk("ready_before", CoreReady, 1);
        START = 1'b1;
        t_select = ts;
        in_valid = 1'($urandom);
        out_ready = 1'($urandom);
        core_done = 1'b0;
        @(negedge CLK);
        edges = 1;
        chk("ready_drop", CoreReady, 0);
        chk("load_en", inputBuffer_en, 1);
        chk("t_sel_q", t_sel_q, ts);
        writes = 0;
        guard = 0;
        while (inputBuffer_en && guard < 500) begin
            chk("load_idx", sample_idx, writes);
            START = hold | 1'($urandom);
            t_select = 2'($urandom);
            in_valid = stall ? 1'($urandom) : 1'b1;
            out_ready = 1'($urandom);
            core_done = 1'($urandom);
            @(negedge CLK);
            edges++;
            guard++;
            if (in_valid)
                writes++;
        end
        chk("writes", writes, BLOCK_LEN);
        chk("go_first", core_go, 1);
        cyc = 0;
        guard = 0;
        while (!CoreReady && !inputBuffer_en && !DataValid && guard < 500) begin
            cyc++;
            if (cyc == 2)
                chk("go_pulse", core_go, 0);
            core_done = (ts == 2'b11) ? (cyc == 1 || cyc == ext_dly + 1) : 1'($urandom);
            in_valid = 1'($urandom);
            out_ready = 1'($urandom);
            START = hold | 1'($urandom);
            @(negedge CLK);
            edges++;
            guard++;
        end
        core_done = 1'b0;
        chk("compute_cycles", cyc, lat);
        chk("drain_valid", DataValid, 1);
        xfers = 0;
        guard = 0;
        while (DataValid && guard < 500) begin
            chk("drain_idx", sample_idx, xfers);
            chk("obuf_en", outputBuffer_en, 1);
            out_ready = stall ? 1'($urandom) : 1'b1;
            in_valid = 1'($urandom);
            START = hold | 1'($urandom);
            @(negedge CLK);
            edges++;
            guard++;
            if (out_ready)
                xfers++;
        end
        exp_blk = (exp_blk + 1) % (1 << CNT_W);
        chk("xfers", xfers, BLOCK_LEN);
        chk("ready_after", CoreReady, 1);
        chk("idx_after", sample_idx, 0);
        chk("blk_cnt", blk_cnt, exp_blk);
        chk("t_sel_hold", t_sel_q, ts);
        if (!stall)
            chk("latency", edges, 2 * BLOCK_LEN + lat + 1);
        if (!hold)
            START = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        START = 1'b0;
        t_select = 2'b00;
        in_valid = 1'b0;
        core_done = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge CLK);
        check_reset_values();
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'($urandom);
            out_ready = 1'($urandom);
            core_done = 1'($urandom);
            @(negedge CLK);
            chk("idle_ready", CoreReady, 1);
            chk("idle_idx", sample_idx, 0);
        end
        core_done = 1'b0;
        run_block(2'b00, 0, 1'b0, 1'b0);
        run_block(2'b01, 0, 1'b0, 1'b0);
        run_block(2'b10, 0, 1'b0, 1'b0);
        run_block(2'b11, 20, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            run_block(2'($urandom), int'($urandom_range(1, 40)), 1'b1, 1'b0);
        START = 1'b1;
        t_select = 2'b10;
        in_valid = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (BLOCK_LEN + 5) @(negedge CLK);
        chk("mid_compute", CoreReady | inputBuffer_en | DataValid, 0);
        #2 RESET = 1'b1;
        #1 check_reset_values();
        @(negedge CLK);
        RESET = 1'b0;
        exp_blk = 0;
        run_block(2'b00, 0, 1'b0, 1'b0);
        #2 RESET = 1'b1;
        #1 chk("rst2_blk", blk_cnt, 0);
        @(negedge CLK);
        RESET = 1'b0;
        exp_blk = 0;
        for (int i = 0; i < 16; i++)
            run_block(2'($urandom), int'($urandom_range(1, 10)), 1'b0, 1'b1);
        START = 1'b0;
        chk("wrap", blk_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dsp_core_sequencer.md
# dsp_core_sequencer

Top-level sequencer for the hybrid DSP core: on START it loads one block of BLOCK_LEN samples into the input buffer, launches the core for the transform chosen by t_select, then drains BLOCK_LEN results through the output buffer with a valid/ready handshake. It replaces ad-hoc enable logic with one four-state machine and owns every buffer enable, core launch and status flag.

## Interface
- BLOCK_LEN, 8: samples per block; power of two, 2..256.
- CNT_W, 16: width of the completed-block counter.
- CLK  in  1  clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  request to process one block; sampled only in IDLE.
- t_select  in  2  transform select; latched on accepted START.
- in_valid  in  1  an input sample is present this cycle.
- core_done  in  1  core completion strobe; used only when t_sel_q = 2'b11.
- out_ready  in  1  downstream accepts a result this cycle.
- inputBuffer_en  out  1  input buffer write enable; high for the whole of LOAD.
- sample_idx  out  log2(BLOCK_LEN)  buffer address for the current load or drain transfer.
- core_go  out  1  one-cycle core launch pulse.
- outputBuffer_en  out  1  output buffer read enable; equal to DataValid.
- DataValid  out  1  a result is presented; high for the whole of DRAIN.
- CoreReady  out  1  high only in IDLE.
- t_sel_q  out  2  latched transform select.
- blk_cnt  out  CNT_W  count of completed blocks; wraps modulo 2^CNT_W.

## Operation
- States: IDLE, LOAD, COMPUTE, DRAIN. Moore outputs are decoded from the registered state. core_go is registered.
- IDLE -> LOAD when START=1. On the same edge: t_sel_q <= t_select and sample_idx <= 0. START in any other state is ignored and is not queued.
- LOAD:
  - A sample is written when in_valid=1; sample_idx then increments.
  - On the write at sample_idx = BLOCK_LEN-1: sample_idx <= 0, go to COMPUTE.
  - Stalls indefinitely while in_valid=0.
- COMPUTE:
  - core_go=1 on the first COMPUTE cycle only.
  - Fixed latency L = 8 << t_sel_q: 8, 16 or 32 cycles for 00/01/10. Leave after exactly L cycles in COMPUTE. core_done is ignored.
  - For t_sel_q = 11: core_done is ignored in the first COMPUTE cycle. Afterwards, core_done=1 moves the state to DRAIN on the next edge. There is no timeout; only RESET leaves a hung core.
- DRAIN:
  - A transfer occurs when DataValid & out_ready; sample_idx then increments.
  - DataValid must stay high and sample_idx stable while out_ready=0.
  - On transfer BLOCK_LEN-1: go to IDLE, sample_idx <= 0, blk_cnt <= blk_cnt+1 (wraps to 0 at 2^CNT_W-1).
- Compute cycle counter: 6 bits, cleared on COMPUTE entry, enabled only in COMPUTE.

## Timing
- RESET values:
  - state = IDLE.
  - All enables, core_go and DataValid = 0.
  - CoreReady = 1.
  - sample_idx, t_sel_q, blk_cnt and the cycle counter = 0.
- Asserting RESET in any state returns to IDLE immediately (asynchronously). The partial block is discarded and blk_cnt is cleared.
- START to first inputBuffer_en: 1 cycle.
- Minimum block latency (START edge to IDLE re-entry), with in_valid and out_ready held high: 1 + BLOCK_LEN + L + BLOCK_LEN cycles.
- START held high continuously starts a new block on the first IDLE cycle after each block completes. CoreReady is high for exactly that one cycle.
- in_valid during COMPUTE or DRAIN, and out_ready outside DRAIN: no effect.

## Structure
- Shared package dsp_ctrl_pkg holds:
  - the state enum;
  - T_SEL_8 / T_SEL_16 / T_SEL_32 / T_SEL_EXT encodings;
  - the latency base constant (8).
- One sub-module, seq_counter: parameterised width, synchronous clear, enable, asynchronous reset. It is instantiated for sample_idx, the compute cycle counter and blk_cnt.

## Test plan
- Reset, START pulse, t_select=00, in_valid and out_ready held high -> inputBuffer_en high 8 cycles, core_go one pulse, COMPUTE 8 cycles, DataValid high 8 cycles, blk_cnt=1, total 25 cycles.
- t_select=11, core_done pulsed 20 cycles after core_go -> DRAIN begins on the next cycle. A core_done coincident with core_go has no effect.
- in_valid toggling 1/0 in LOAD and out_ready low for 3 cycles mid-DRAIN -> exactly 8 writes and 8 transfers; sample_idx holds during stalls.
- START pulsed during LOAD, COMPUTE and DRAIN -> ignored; exactly one block is processed; CoreReady stays 0 until IDLE.
- RESET asserted mid-COMPUTE -> all outputs return to reset values asynchronously; the next START runs a clean block.
- CNT_W=4, 16 back-to-back blocks with START held high -> blk_cnt wraps to 0.
